// File: rtl/dither_requantizer_if.sv
// dither_requantizer_if: input/output stream handshake and LFSR tap bundle
interface dither_requantizer_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             lfsr_bit;
   logic             lfsr_en;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             sat_flag;
   modport master (
      output in_valid, in_data, lfsr_bit, out_ready,
      input  in_ready, lfsr_en, out_valid, out_data, sat_flag
   );
   modport slave (
      input  in_valid, in_data, lfsr_bit, out_ready,
      output in_ready, lfsr_en, out_valid, out_data, sat_flag
   );
endinterface

// File: rtl/dither_requantizer.sv
// dither_requantizer: LFSR-dithered saturating requantizer; REQUANT_TPDF_EN selects triangular dither
module dither_requantizer #(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 8,
   parameter int DITHER_W = 8
) (
   input logic clk,
   input logic rst,
   dither_requantizer_if.slave bus
);
   localparam int S   = IN_W - OUT_W;
   localparam int DSH = S - DITHER_W;
`ifdef REQUANT_TPDF_EN
   localparam int DSR_W = 2 * DITHER_W;
`else
   localparam int DSR_W = DITHER_W;
`endif
   localparam int CNT_W = $clog2(DSR_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DSR_W);

   typedef enum logic {FILL, ARMED} state_t;

   state_t              state;
   logic [DSR_W-1:0]    dsr_q, dsr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [OUT_W-1:0]    out_data_q, out_data_d;
   logic                sat_q, sat_d;
   logic                in_ready_w, lfsr_en_w, accept;
   logic signed [IN_W:0] d_w, sum_w;
   logic signed [OUT_W:0] q_w;
   logic                sat_w;
   logic [OUT_W-1:0]    res_w;
   logic                unused_lo;

`ifdef REQUANT_TPDF_EN
   logic signed [DITHER_W:0] diff_w;
   assign diff_w = $signed({1'b0, dsr_q[DSR_W-1:DITHER_W]}) - $signed({1'b0, dsr_q[DITHER_W-1:0]});
   assign d_w    = $signed({{(IN_W-DITHER_W){diff_w[DITHER_W]}}, diff_w}) <<< DSH;
`else
   assign d_w    = $signed({{(IN_W+1-DITHER_W){1'b0}}, dsr_q}) <<< DSH;
`endif

   // state decode and handshake: a word is armed once all dither bits are in
   always_comb begin
      state      = (cnt_q == CNT_FULL) ? ARMED : FILL;
      in_ready_w = (state == ARMED) && (!out_valid_q || bus.out_ready);
      accept     = bus.in_valid && in_ready_w;
      lfsr_en_w  = (state == FILL) || accept;
   end

   // dither injection below the cut point, truncation and clipping
   always_comb begin
      sum_w     = $signed({bus.in_data[IN_W-1], bus.in_data}) + d_w;
      q_w       = sum_w[IN_W:S];
      unused_lo = ^sum_w[S-1:0];
      sat_w     = q_w[OUT_W] ^ q_w[OUT_W-1];
      res_w     = sat_w ? {q_w[OUT_W], {(OUT_W-1){~q_w[OUT_W]}}} : q_w[OUT_W-1:0];
   end

   // next state: the bit shifted in on accept already belongs to the next word
   always_comb begin
      dsr_d       = lfsr_en_w ? DSR_W'({dsr_q, bus.lfsr_bit}) : dsr_q;
      cnt_d       = accept ? CNT_W'(1) : (lfsr_en_w ? cnt_q + CNT_W'(1) : cnt_q);
      out_valid_d = accept || (out_valid_q && !bus.out_ready);
      out_data_d  = accept ? res_w : out_data_q;
      sat_d       = accept ? sat_w : sat_q;
   end

   // state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dsr_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_q       <= 1'b0;
      end else begin
         dsr_q       <= dsr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sat_q       <= sat_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.lfsr_en   = lfsr_en_w;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_dither_requantizer.sv
// tb_dither_requantizer: directed and random checks against a bit-stream reference model
module tb_dither_requantizer;
   localparam int IN_W = 16;
   localparam int OUT_W = 8;
   localparam int DW = 8;
   localparam int S = IN_W - OUT_W;
`ifdef REQUANT_TPDF_EN
   localparam int NB = 2 * DW;
`else
   localparam int NB = DW;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dither_requantizer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifc();
   dither_requantizer #(.IN_W(IN_W), .OUT_W(OUT_W), .DITHER_W(DW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   int checks = 0;
   int errors = 0;
   bit bq[$];
   logic ev;
   logic [OUT_W-1:0] eo;
   logic es;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic predict(input logic [IN_W-1:0] din);
      int a, b, d, v, sum, q;
      a = 0;
      b = 0;
      for (int i = 0; i < DW; i++) a = a * 2 + int'(bq.pop_front());
`ifdef REQUANT_TPDF_EN
      for (int i = 0; i < DW; i++) b = b * 2 + int'(bq.pop_front());
`endif
      d = a - b;
      v = $signed(din);
      sum = v + d * (1 << (S - DW));
      q = sum >>> S;
      if (q > 127) begin eo = 8'h7F; es = 1'b1; end
      else if (q < -128) begin eo = 8'h80; es = 1'b1; end
      else begin eo = q[7:0]; es = 1'b0; end
   endtask

   task automatic cyc();
      logic rdy, en, acc;
      #1;
      rdy = (bq.size() == NB) && (!ev || ifc.out_ready);
      acc = rdy && ifc.in_valid;
      en = (bq.size() < NB) || acc;
      chk("in_ready", ifc.in_ready, rdy);
      chk("lfsr_en", ifc.lfsr_en, en);
      if (acc) begin predict(ifc.in_data); ev = 1'b1; end
      else if (ifc.out_ready) ev = 1'b0;
      if (en) bq.push_back(ifc.lfsr_bit);
      @(posedge clk);
      #1;
      chk("out_valid", ifc.out_valid, ev);
      if (ev) begin
         chk("out_data", ifc.out_data, eo);
         chk("sat_flag", ifc.sat_flag, es);
      end
   endtask

   task automatic do_reset(input logic iv);
      int k;
      ifc.in_valid = iv;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", ifc.out_valid, 1'b0);
      chk("rst_out_data", ifc.out_data, 0);
      chk("rst_sat_flag", ifc.sat_flag, 1'b0);
      chk("rst_in_ready", ifc.in_ready, 1'b0);
      chk("rst_lfsr_en", ifc.lfsr_en, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bq.delete();
      ev = 1'b0;
      k = 0;
      while (!ifc.in_ready && k < 40) begin cyc(); k++; end
      chk("ready_latency", k, NB);
   endtask

   task automatic vec(input logic b, input logic [IN_W-1:0] din, input logic [7:0] o, input logic s);
      ifc.lfsr_bit = b;
      ifc.out_ready = 1'b1;
      do_reset(1'b0);
      ifc.in_data = din;
      ifc.in_valid = 1'b1;
      cyc();
      ifc.in_valid = 1'b0;
      chk("vec_valid", ifc.out_valid, 1'b1);
`ifndef REQUANT_TPDF_EN
      chk("vec_data", ifc.out_data, o);
      chk("vec_sat", ifc.sat_flag, s);
`endif
      cyc();
   endtask

   initial begin
      int acc_cnt;
      logic [OUT_W-1:0] held;
      ifc.in_valid = 1'b0;
      ifc.in_data = '0;
      ifc.lfsr_bit = 1'b0;
      ifc.out_ready = 1'b1;
      ev = 1'b0;
      eo = '0;
      es = 1'b0;
      vec(1'b0, 16'h1234, 8'h12, 1'b0);
      vec(1'b1, 16'h1201, 8'h13, 1'b0);
      vec(1'b1, 16'h1200, 8'h12, 1'b0);
      vec(1'b1, 16'h7FFF, 8'h7F, 1'b1);
      vec(1'b0, 16'h8000, 8'h80, 1'b0);
      do_reset(1'b1);
      acc_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         ifc.lfsr_bit = 1'($urandom);
         ifc.in_data = 16'($urandom);
         if (ifc.in_ready) acc_cnt++;
         cyc();
      end
      chk("accept_rate", acc_cnt, (40 + NB - 1) / NB);
      do_reset(1'b0);
      ifc.out_ready = 1'b0;
      ifc.in_valid = 1'b1;
      ifc.in_data = 16'($urandom);
      cyc();
      held = ifc.out_data;
      for (int i = 0; i < 20; i++) begin
         ifc.lfsr_bit = 1'($urandom);
         ifc.in_data = 16'($urandom);
         cyc();
      end
      chk("stall_ready", ifc.in_ready, 1'b0);
      chk("stall_lfsr_en", ifc.lfsr_en, 1'b0);
      chk("stall_hold", ifc.out_data, held);
      ifc.out_ready = 1'b1;
      cyc();
      chk("b2b_valid", ifc.out_valid, 1'b1);
      ifc.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bq.delete();
      ev = 1'b0;
      repeat (5) cyc();
      do_reset(1'b0);
      ifc.out_ready = 1'b0;
      ifc.in_valid = 1'b1;
      cyc();
      ifc.in_valid = 1'b0;
      cyc();
      chk("pre_rst_valid", ifc.out_valid, 1'b1);
      do_reset(1'b0);
      for (int i = 0; i < 800; i++) begin
         ifc.lfsr_bit = 1'($urandom);
         ifc.in_valid = ($urandom_range(0, 3) != 0);
         ifc.out_ready = ($urandom_range(0, 2) != 0);
         ifc.in_data = ($urandom_range(0, 3) == 0) ? (16'h7F00 | 16'($urandom_range(0, 255))) : 16'($urandom);
         cyc();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
